// File: rtl/matrix_row_streamer.sv
// Streams every row of a latency-fixed matrix read port through a small credit-managed FIFO.
// Issue is gated by credits so a returning row always has a FIFO slot waiting for it.
module matrix_row_streamer #(
  parameter  int NUM_ROWS       = 3,
  parameter  int NUM_COLS       = 5,
  parameter  int SCALAR_BITS    = 32,
  parameter  int MEMORY_LATENCY = 2,
  localparam int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int ROW_SIZE       = NUM_COLS * SCALAR_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ROW_ADDR_WIDTH-1:0] row_addr,
  output logic                      row_addr_ready,
  input  logic                      row_valid,
  input  logic [ROW_SIZE-1:0]       row_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROW_SIZE-1:0]       out_data,
  output logic [ROW_ADDR_WIDTH-1:0] out_row_idx,
  output logic                      out_last,
  output logic                      overflow_err
);

  localparam int FIFO_DEPTH = MEMORY_LATENCY + 2;
  localparam int CRD_W      = $clog2(FIFO_DEPTH + 1);
  localparam int OCNT_W     = $clog2(NUM_ROWS + 1);
  localparam int ENTRY_W    = ROW_SIZE + ROW_ADDR_WIDTH;

  localparam logic [CRD_W-1:0]          CRD_MAX   = CRD_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0]          CRD_ONE   = CRD_W'(1);
  localparam logic [CRD_W-1:0]          CRD_ZERO  = CRD_W'(0);
  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW  = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [ROW_ADDR_WIDTH-1:0] ADDR_ONE  = ROW_ADDR_WIDTH'(1);
  localparam logic [ROW_ADDR_WIDTH-1:0] ADDR_ZERO = ROW_ADDR_WIDTH'(0);
  localparam logic [OCNT_W-1:0]         OCNT_ALL  = OCNT_W'(NUM_ROWS);
  localparam logic [OCNT_W-1:0]         OCNT_ONE  = OCNT_W'(1);
  localparam logic [OCNT_W-1:0]         OCNT_ZERO = OCNT_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ROW_ADDR_WIDTH-1:0]   ret_cnt_q, ret_cnt_d;
  logic [OCNT_W-1:0]           out_cnt_q, out_cnt_d;
  logic [CRD_W-1:0]            credit_q, credit_d;
  logic [CRD_W-1:0]            count_q, count_d;
  logic [ENTRY_W-1:0]          fifo_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]          fifo_d [FIFO_DEPTH];
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic                        row_addr_ready_q, row_addr_ready_d;
  logic [ROW_ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        overflow_q, overflow_d;

  logic                        issue_s, pop_s, push_s, full_s, accept_s;
  logic [CRD_W-1:0]            wr_idx_s;
  logic [ENTRY_W-1:0]          entry_s;

  assign issue_s  = row_addr_ready_q;
  assign pop_s    = out_valid_q & out_ready;
  assign full_s   = (count_q == CRD_MAX);
  assign accept_s = start & (state_q == S_IDLE);
  assign push_s   = row_valid & (state_q != S_IDLE) & ~full_s;
  assign entry_s  = {row_in, ret_cnt_q};

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      issue_cnt_q      <= ADDR_ZERO;
      ret_cnt_q        <= ADDR_ZERO;
      out_cnt_q        <= OCNT_ZERO;
      credit_q         <= CRD_MAX;
      count_q          <= CRD_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= {ENTRY_W{1'b0}};
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      row_addr_ready_q <= 1'b0;
      row_addr_q       <= ADDR_ZERO;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      issue_cnt_q      <= issue_cnt_d;
      ret_cnt_q        <= ret_cnt_d;
      out_cnt_q        <= out_cnt_d;
      credit_q         <= credit_d;
      count_q          <= count_d;
      fifo_q           <= fifo_d;
      out_valid_q      <= out_valid_d;
      out_last_q       <= out_last_d;
      row_addr_ready_q <= row_addr_ready_d;
      row_addr_q       <= row_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      overflow_q       <= overflow_d;
    end
  end

  // Next-state logic; DRAIN looks at the next output count so done lands right after the last handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = (issue_s && (issue_cnt_q == LAST_ROW)) ? S_DRAIN : S_ISSUE;
      S_DRAIN: state_d = (out_cnt_d == OCNT_ALL) ? S_DONE : S_DRAIN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, computed from next-state values so every port comes straight from a flop
  always_comb begin
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
    row_addr_ready_d = (state_d == S_ISSUE) && (credit_d != CRD_ZERO);
    row_addr_d       = issue_cnt_d;
  end

  // Pass counters and issue credits
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    out_cnt_d   = out_cnt_q;
    if (accept_s) begin
      issue_cnt_d = ADDR_ZERO;
      ret_cnt_d   = ADDR_ZERO;
      out_cnt_d   = OCNT_ZERO;
    end else begin
      issue_cnt_d = (issue_s && (issue_cnt_q != LAST_ROW)) ? issue_cnt_q + ADDR_ONE : issue_cnt_q;
      ret_cnt_d   = (push_s && (ret_cnt_q != LAST_ROW)) ? ret_cnt_q + ADDR_ONE : ret_cnt_q;
      out_cnt_d   = (pop_s && (out_cnt_q != OCNT_ALL)) ? out_cnt_q + OCNT_ONE : out_cnt_q;
    end
    credit_d = credit_q;
    if (issue_s && !pop_s && (credit_q != CRD_ZERO)) begin
      credit_d = credit_q - CRD_ONE;
    end else if (pop_s && !issue_s && (credit_q != CRD_MAX)) begin
      credit_d = credit_q + CRD_ONE;
    end else begin
      credit_d = credit_q;
    end
  end

  // Shift-register FIFO: entry 0 is the output register, a push lands behind the surviving entries
  always_comb begin
    fifo_d   = fifo_q;
    wr_idx_s = pop_s ? (count_q - CRD_ONE) : count_q;
    for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
      fifo_d[i] = pop_s ? fifo_q[i+1] : fifo_q[i];
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_d[i] = (push_s && (wr_idx_s == CRD_W'(i))) ? entry_s : fifo_d[i];
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CRD_ONE;
      2'b01:   count_d = count_q - CRD_ONE;
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != CRD_ZERO);
    out_last_d  = (count_d != CRD_ZERO) && (fifo_d[0][ROW_ADDR_WIDTH-1:0] == LAST_ROW);
    overflow_d  = overflow_q | (row_valid & ((state_q == S_IDLE) | full_s));
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign row_addr       = row_addr_q;
  assign row_addr_ready = row_addr_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = fifo_q[0][ENTRY_W-1:ROW_ADDR_WIDTH];
  assign out_row_idx    = fifo_q[0][ROW_ADDR_WIDTH-1:0];
  assign out_last       = out_last_q;
  assign overflow_err   = overflow_q;

endmodule

// File: tb/tb_matrix_row_streamer.sv
// Bench for matrix_row_streamer: two instances (3 rows and 8 rows) each fed by a fixed-latency
// matrix model; expected rows are queued at start and checked as they handshake out.
module tb_matrix_row_streamer;

  localparam int ML  = 2;
  localparam int RS  = 160;
  localparam int AW3 = 2;
  localparam int AW8 = 3;

  logic clk, rst_n;
  logic start3, busy3, done3, rar3, rv3, ov3, rdy3, ol3, ovf3;
  logic [AW3-1:0] ra3, oi3;
  logic [RS-1:0]  rin3, od3;
  logic start8, busy8, done8, rar8, rv8, ov8, rdy8, ol8, ovf8;
  logic [AW8-1:0] ra8, oi8;
  logic [RS-1:0]  rin8, od8;
  logic inj3;

  int total, bad;

  typedef struct {
    int            idx;
    logic [RS-1:0] data;
  } exp_t;
  exp_t sb3[$];
  exp_t sb8[$];

  matrix_row_streamer #(.NUM_ROWS(3), .NUM_COLS(5), .SCALAR_BITS(32), .MEMORY_LATENCY(ML)) u_dut3 (
    .clk(clk), .rst(rst_n), .start(start3), .busy(busy3), .done(done3),
    .row_addr(ra3), .row_addr_ready(rar3), .row_valid(rv3), .row_in(rin3),
    .out_valid(ov3), .out_ready(rdy3), .out_data(od3), .out_row_idx(oi3),
    .out_last(ol3), .overflow_err(ovf3));

  matrix_row_streamer #(.NUM_ROWS(8), .NUM_COLS(5), .SCALAR_BITS(32), .MEMORY_LATENCY(ML)) u_dut8 (
    .clk(clk), .rst(rst_n), .start(start8), .busy(busy8), .done(done8),
    .row_addr(ra8), .row_addr_ready(rar8), .row_valid(rv8), .row_in(rin8),
    .out_valid(ov8), .out_ready(rdy8), .out_data(od8), .out_row_idx(oi8),
    .out_last(ol8), .overflow_err(ovf8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [RS-1:0] mk_row(input int r);
    logic [RS-1:0] v;
    v = '0;
    for (int c = 0; c < 5; c++) v[c*32 +: 32] = {8'(r), 8'(c), 16'hA55A ^ 16'(r * 37 + c * 5)};
    return v;
  endfunction

  // Matrix models: request seen at a rising edge returns ML cycles later; data is junk off the valid cycle
  logic v3 [ML];
  logic [AW3-1:0] a3 [ML];
  logic v8 [ML];
  logic [AW8-1:0] a8 [ML];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ML; i++) begin
        v3[i] <= 1'b0; a3[i] <= '0; v8[i] <= 1'b0; a8[i] <= '0;
      end
    end else begin
      v3[0] <= rar3; a3[0] <= ra3; v8[0] <= rar8; a8[0] <= ra8;
      for (int i = 1; i < ML; i++) begin
        v3[i] <= v3[i-1]; a3[i] <= a3[i-1]; v8[i] <= v8[i-1]; a8[i] <= a8[i-1];
      end
    end
  end
  assign rv3  = v3[ML-1] | inj3;
  assign rin3 = v3[ML-1] ? mk_row(int'(a3[ML-1])) : {RS{1'b1}};
  assign rv8  = v8[ML-1];
  assign rin8 = v8[ML-1] ? mk_row(int'(a8[ML-1])) : {RS{1'b1}};

  task automatic load_sb3();
    exp_t e;
    for (int r = 0; r < 3; r++) begin e.idx = r; e.data = mk_row(r); sb3.push_back(e); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start3 = 1'b0; start8 = 1'b0; rdy3 = 1'b1; rdy8 = 1'b1; inj3 = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy3, done3, rar3, ra3, ov3, od3, oi3, ol3, ovf3} !== '0) begin
      bad++;
      $display("FAIL reset_dut3 got=%h want=0", {busy3, done3, rar3, ra3, ov3, od3, oi3, ol3, ovf3});
    end
    total++;
    if ({busy8, done8, rar8, ra8, ov8, od8, oi8, ol8, ovf8} !== '0) begin
      bad++;
      $display("FAIL reset_dut8 got=%h want=0", {busy8, done8, rar8, ra8, ov8, od8, oi8, ol8, ovf8});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Cycle-exact pass: obs = {ovf, rar, addr, ov, idx, last, done, busy}
  task automatic test_latency();
    logic [9:0] exp_tab [1:8];
    logic [9:0] obs;
    exp_t e;
    exp_tab = '{10'b0_1_00_0_00_0_0_1, 10'b0_1_01_0_00_0_0_1, 10'b0_1_10_0_00_0_0_1,
                10'b0_0_00_1_00_0_0_1, 10'b0_0_00_1_01_0_0_1, 10'b0_0_00_1_10_1_0_1,
                10'b0_0_00_0_00_0_1_1, 10'b0_0_00_0_00_0_0_0};
    load_sb3();
    rdy3 = 1'b1; start3 = 1'b1;
    total++;
    if (busy3 !== 1'b0) begin bad++; $display("FAIL lat_c0_busy got=%b want=0", busy3); end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start3 = 1'b0;
      obs = {ovf3, rar3, rar3 ? ra3 : 2'b00, ov3, ov3 ? oi3 : 2'b00, ol3, done3, busy3};
      total++;
      if (obs !== exp_tab[cyc]) begin
        bad++; $display("FAIL lat_cycle%0d got=%b want=%b", cyc, obs, exp_tab[cyc]);
      end
      if (ov3 && rdy3) begin
        total++;
        if (sb3.size() == 0) begin
          bad++; $display("FAIL lat_extra_row got idx=%0d want none", oi3);
        end else begin
          e = sb3.pop_front();
          if ({oi3, od3} !== {AW3'(e.idx), e.data}) begin
            bad++; $display("FAIL lat_row got=%0d/%h want=%0d/%h", oi3, od3, e.idx, e.data);
          end
        end
      end
    end
    total++;
    if (sb3.size() != 0) begin bad++; $display("FAIL lat_missing got=%0d left want=0", sb3.size()); end
    sb3.delete();
  endtask

  task automatic test_backpressure();
    int issues, dones, first_hs, last_hs;
    logic have_held;
    logic [AW3+RS-1:0] held;
    exp_t e;
    issues = 0; dones = 0; first_hs = -1; last_hs = -1; have_held = 1'b0; held = '0;
    load_sb3();
    start3 = 1'b1; rdy3 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start3 = 1'b0;
      rdy3 = (cyc >= 10);
      if (rar3) issues++;
      if (done3) dones++;
      if (ov3 && !rdy3) begin
        if (have_held) begin
          total++;
          if ({oi3, od3} !== held) begin bad++; $display("FAIL bp_hold c%0d got=%h want=%h", cyc, {oi3, od3}, held); end
        end
        held = {oi3, od3}; have_held = 1'b1;
      end
      if (ov3 && rdy3) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        total++;
        if (sb3.size() == 0) begin
          bad++; $display("FAIL bp_extra_row got idx=%0d want none", oi3);
        end else begin
          e = sb3.pop_front();
          if ({oi3, od3, ol3} !== {AW3'(e.idx), e.data, e.idx == 2}) begin
            bad++; $display("FAIL bp_row got=%0d/%b want=%0d/%b", oi3, ol3, e.idx, e.idx == 2);
          end
        end
      end
    end
    total++; if (issues != 3) begin bad++; $display("FAIL bp_issues got=%0d want=3", issues); end
    total++; if (dones != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", dones); end
    total++; if (first_hs != 10 || last_hs != 12) begin
      bad++; $display("FAIL bp_drain got=%0d..%0d want=10..12", first_hs, last_hs);
    end
    total++; if (ovf3 !== 1'b0) begin bad++; $display("FAIL bp_overflow got=%b want=0", ovf3); end
    total++; if (sb3.size() != 0) begin bad++; $display("FAIL bp_missing got=%0d want=0", sb3.size()); end
    sb3.delete();
    rdy3 = 1'b1;
  endtask

  task automatic test_toggle();
    int exp_addr, outstanding, max_out, hs, dones, issues;
    exp_t e;
    exp_addr = 0; outstanding = 0; max_out = 0; hs = 0; dones = 0; issues = 0;
    for (int r = 0; r < 8; r++) begin e.idx = r; e.data = mk_row(r); sb8.push_back(e); end
    start8 = 1'b1; rdy8 = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start8 = 1'b0;
      rdy8 = (cyc % 2 == 0);
      if (rar8) begin
        issues++; total++;
        if (ra8 !== AW8'(exp_addr)) begin bad++; $display("FAIL tog_addr got=%0d want=%0d", ra8, exp_addr); end
        exp_addr++; outstanding++;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (ov8 && rdy8) begin
        hs++; outstanding--; total++;
        if (sb8.size() == 0) begin
          bad++; $display("FAIL tog_extra_row got idx=%0d want none", oi8);
        end else begin
          e = sb8.pop_front();
          if ({oi8, od8, ol8} !== {AW8'(e.idx), e.data, e.idx == 7}) begin
            bad++; $display("FAIL tog_row got=%0d/%b want=%0d/%b", oi8, ol8, e.idx, e.idx == 7);
          end
        end
      end
      if (done8) dones++;
    end
    total++; if (issues != 8) begin bad++; $display("FAIL tog_issues got=%0d want=8", issues); end
    total++; if (hs != 8) begin bad++; $display("FAIL tog_rows got=%0d want=8", hs); end
    total++; if (dones != 1) begin bad++; $display("FAIL tog_done got=%0d want=1", dones); end
    total++; if (max_out != 4) begin bad++; $display("FAIL tog_inflight got=%0d want=4", max_out); end
    total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL tog_overflow got=%b want=0", ovf8); end
    sb8.delete();
    rdy8 = 1'b1;
  endtask

  task automatic test_restart_ignored();
    int issues, dones, busy_cnt;
    exp_t e;
    issues = 0; dones = 0; busy_cnt = 0;
    load_sb3();
    start3 = 1'b1; rdy3 = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start3 = (cyc == 2 || cyc == 5 || cyc == 7);
      if (rar3) issues++;
      if (done3) dones++;
      if (busy3) busy_cnt++;
      if (ov3 && rdy3) begin
        total++;
        if (sb3.size() == 0) begin
          bad++; $display("FAIL rs_extra_row got idx=%0d want none", oi3);
        end else begin
          e = sb3.pop_front();
          if ({oi3, od3} !== {AW3'(e.idx), e.data}) begin
            bad++; $display("FAIL rs_row got=%0d want=%0d", oi3, e.idx);
          end
        end
      end
    end
    total++; if (issues != 3) begin bad++; $display("FAIL rs_issues got=%0d want=3", issues); end
    total++; if (dones != 1) begin bad++; $display("FAIL rs_done got=%0d want=1", dones); end
    total++; if (busy_cnt != 7) begin bad++; $display("FAIL rs_busy got=%0d want=7", busy_cnt); end
    total++; if (sb3.size() != 0) begin bad++; $display("FAIL rs_missing got=%0d want=0", sb3.size()); end
    sb3.delete();
  endtask

  task automatic test_reset_mid_pass();
    rdy3 = 1'b0; start3 = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start3 = 1'b0;
    end
    total++;
    if (ov3 !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", ov3); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy3, done3, rar3, ra3, ov3, od3, oi3, ol3, ovf3} !== '0) begin
      bad++;
      $display("FAIL mid_async_reset got=%h want=0", {busy3, done3, rar3, ra3, ov3, od3, oi3, ol3, ovf3});
    end
    @(negedge clk);
    rst_n = 1'b1; rdy3 = 1'b1;
    @(negedge clk);
    test_latency();
  endtask

  task automatic test_spurious();
    inj3 = 1'b1;
    @(negedge clk);
    inj3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({ovf3, ov3} !== 2'b10) begin bad++; $display("FAIL spur_sticky got=%b want=10", {ovf3, ov3}); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ovf3 !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b want=0", ovf3); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_latency();
    test_backpressure();
    test_toggle();
    test_restart_ignored();
    test_reset_mid_pass();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
